// File: rtl/rv32_core_mc_if.sv
// Memory-side bus of the multi-cycle RV32 core.
// It carries the instruction fetch port, the data port and the retire/halt status.
interface rv32_core_mc_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        retire;
  logic        halted;

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ready,
    output d_req, d_wen, d_addr, d_wdata,
    input  d_rdata, d_ready,
    output retire, halted
  );

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ready,
    input  d_req, d_wen, d_addr, d_wdata,
    output d_rdata, d_ready,
    input  retire, halted
  );
endinterface

// File: rtl/rv32_core_mc.sv
// Multi-cycle RV32I/RV32E subset core.
// Runs one instruction at a time through IF -> EX (-> MEM), halting on illegal or misaligned flow.
module rv32_core_mc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          BYTE_SWAP = 1'b1,
  parameter int unsigned NUM_REGS  = 32
) (
  input logic             clk,
  input logic             rst,
  rv32_core_mc_if.master  io_bus
);

  localparam int unsigned REG_AW = $clog2(NUM_REGS);

  localparam logic [1:0] S_IF   = 2'd0;
  localparam logic [1:0] S_EX   = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  // Memories are big-endian when BYTE_SWAP is set; the core works little-endian.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    if (BYTE_SWAP) return {w[7:0], w[15:8], w[23:16], w[31:24]};
    else           return w;
  endfunction

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_daddr;
  logic [31:0] r_dwdata;
  logic        r_dwen;
  logic        r_retire;
  logic [31:0] r_regs [NUM_REGS];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;

  logic w_is_alu_r, w_is_addi, w_is_lw, w_is_sw, w_is_br, w_is_jal, w_is_jalr;
  logic w_use_rs1, w_use_rs2, w_use_rd, w_regs_ok, w_legal;

  logic [31:0] w_alu_res;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_jal_tgt;
  logic [31:0] w_jalr_sum;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_ls_addr;
  logic        w_br_taken;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_ir_nxt;
  logic [31:0] w_daddr_nxt;
  logic [31:0] w_dwdata_nxt;
  logic        w_dwen_nxt;
  logic        w_retire_nxt;
  logic        w_rd_we;
  logic [31:0] w_rd_wdata;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  // Register reads; x0 and out-of-range indices read as zero.
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != 5'd0 && 32'(w_rs1) < NUM_REGS) w_rs1_val = r_regs[w_rs1[REG_AW-1:0]];
    if (w_rs2 != 5'd0 && 32'(w_rs2) < NUM_REGS) w_rs2_val = r_regs[w_rs2[REG_AW-1:0]];
  end

  // Instruction decode and legality, including the RV32E register-range limit.
  always_comb begin
    w_is_alu_r = 1'b0;
    w_is_addi  = 1'b0;
    w_is_lw    = 1'b0;
    w_is_sw    = 1'b0;
    w_is_br    = 1'b0;
    w_is_jal   = 1'b0;
    w_is_jalr  = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_use_rd   = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
        if (w_f7 == 7'b0000000 &&
            (w_f3 == 3'b000 || w_f3 == 3'b111 || w_f3 == 3'b110 || w_f3 == 3'b010)) begin
          w_is_alu_r = 1'b1;
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_is_alu_r = 1'b1;
        end
      end
      7'b0010011: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_is_addi = (w_f3 == 3'b000);
      end
      7'b0000011: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_is_lw   = (w_f3 == 3'b010);
      end
      7'b0100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_is_sw   = (w_f3 == 3'b010);
      end
      7'b1100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_is_br   = (w_f3 == 3'b000 || w_f3 == 3'b001);
      end
      7'b1101111: begin
        w_use_rd = 1'b1;
        w_is_jal = 1'b1;
      end
      7'b1100111: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_is_jalr = (w_f3 == 3'b000);
      end
      default: ;
    endcase
    w_regs_ok = !(w_use_rs1 && 32'(w_rs1) >= NUM_REGS) &&
                !(w_use_rs2 && 32'(w_rs2) >= NUM_REGS) &&
                !(w_use_rd  && 32'(w_rd)  >= NUM_REGS);
    w_legal = w_regs_ok && (w_is_alu_r || w_is_addi || w_is_lw || w_is_sw ||
                            w_is_br || w_is_jal || w_is_jalr);
  end

  // ALU result for R-type and ADDI.
  always_comb begin
    w_alu_res = '0;
    if (w_is_addi) begin
      w_alu_res = w_rs1_val + w_imm_i;
    end else begin
      case (w_f3)
        3'b000:  w_alu_res = w_f7[5] ? (w_rs1_val - w_rs2_val) : (w_rs1_val + w_rs2_val);
        3'b111:  w_alu_res = w_rs1_val & w_rs2_val;
        3'b110:  w_alu_res = w_rs1_val | w_rs2_val;
        3'b010:  w_alu_res = {31'b0, $signed(w_rs1_val) < $signed(w_rs2_val)};
        default: w_alu_res = '0;
      endcase
    end
  end

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_tgt   = r_pc + w_imm_b;
  assign w_jal_tgt  = r_pc + w_imm_j;
  assign w_jalr_sum = w_rs1_val + w_imm_i;
  assign w_jalr_tgt = {w_jalr_sum[31:1], 1'b0};
  assign w_ls_addr  = w_rs1_val + (w_is_sw ? w_imm_s : w_imm_i);
  assign w_br_taken = w_f3[0] ? (w_rs1_val != w_rs2_val) : (w_rs1_val == w_rs2_val);

  // Next-state, PC and register write-back for each FSM state.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_daddr_nxt  = r_daddr;
    w_dwdata_nxt = r_dwdata;
    w_dwen_nxt   = r_dwen;
    w_retire_nxt = 1'b0;
    w_rd_we      = 1'b0;
    w_rd_wdata   = '0;
    case (r_state)
      S_IF: begin
        if (io_bus.i_ready) begin
          w_ir_nxt    = swap_bytes(io_bus.i_rdata);
          w_state_nxt = S_EX;
        end
      end
      S_EX: begin
        if (!w_legal) begin
          w_state_nxt = S_HALT;
        end else if (w_is_alu_r || w_is_addi) begin
          w_rd_we      = 1'b1;
          w_rd_wdata   = w_alu_res;
          w_pc_nxt     = w_pc_plus4;
          w_retire_nxt = 1'b1;
          w_state_nxt  = S_IF;
        end else if (w_is_br) begin
          if (w_br_taken && w_br_tgt[1]) begin
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt     = w_br_taken ? w_br_tgt : w_pc_plus4;
            w_retire_nxt = 1'b1;
            w_state_nxt  = S_IF;
          end
        end else if (w_is_jal || w_is_jalr) begin
          if ((w_is_jal ? w_jal_tgt[1] : w_jalr_tgt[1])) begin
            w_state_nxt = S_HALT;
          end else begin
            // rs1 was read combinationally above, so rd == rs1 is harmless.
            w_rd_we      = 1'b1;
            w_rd_wdata   = w_pc_plus4;
            w_pc_nxt     = w_is_jal ? w_jal_tgt : w_jalr_tgt;
            w_retire_nxt = 1'b1;
            w_state_nxt  = S_IF;
          end
        end else begin
          w_daddr_nxt  = w_ls_addr;
          w_dwdata_nxt = swap_bytes(w_rs2_val);
          w_dwen_nxt   = w_is_sw;
          w_state_nxt  = S_MEM;
        end
      end
      S_MEM: begin
        if (io_bus.d_ready) begin
          w_rd_we      = !r_dwen;
          w_rd_wdata   = swap_bytes(io_bus.d_rdata);
          w_pc_nxt     = w_pc_plus4;
          w_retire_nxt = 1'b1;
          w_state_nxt  = S_IF;
        end
      end
      default: ;
    endcase
  end

  // Control state; reset abandons any outstanding fetch or data access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IF;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_dwen   <= 1'b0;
      r_retire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_daddr  <= w_daddr_nxt;
      r_dwdata <= w_dwdata_nxt;
      r_dwen   <= w_dwen_nxt;
      r_retire <= w_retire_nxt;
    end
  end

  // Register file write; x0 writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_rd_we && w_rd != 5'd0) begin
      r_regs[w_rd[REG_AW-1:0]] <= w_rd_wdata;
    end
  end

  assign io_bus.i_req   = (r_state == S_IF);
  assign io_bus.i_addr  = r_pc;
  assign io_bus.d_req   = (r_state == S_MEM);
  assign io_bus.d_wen   = (r_state == S_MEM) && r_dwen;
  assign io_bus.d_addr  = (r_state == S_MEM) ? r_daddr : 32'd0;
  assign io_bus.d_wdata = (r_state == S_MEM) ? r_dwdata : 32'd0;
  assign io_bus.retire  = r_retire;
  assign io_bus.halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_rv32_core_mc.sv
// Directed bench for rv32_core_mc: a big-endian I/D memory model with adjustable wait states,
// plus a second RV32E instance for the register-range check.
module tb_rv32_core_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_core_mc_if bus ();
  rv32_core_mc_if bus_e ();

  rv32_core_mc #(.RESET_PC(32'h0), .BYTE_SWAP(1'b1), .NUM_REGS(32)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  rv32_core_mc #(.RESET_PC(32'h0), .BYTE_SWAP(1'b1), .NUM_REGS(16)) u_dut_e (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_e)
  );

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: imem holds plain instructions, dmem holds raw big-endian bus words.
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  int i_lat = 0, st_lat = 0, ld_lat = 0;
  logic d_force = 1'b0;
  int icnt = 0, dcnt = 0;

  assign bus.i_rdata = bswap(imem[bus.i_addr[7:2]]);
  assign bus.i_ready = bus.i_req && (icnt >= i_lat);
  assign bus.d_rdata = dmem[bus.d_addr[7:2]];
  assign bus.d_ready = (bus.d_req && (dcnt >= (bus.d_wen ? st_lat : ld_lat))) || d_force;

  always @(posedge clk) begin
    if (rst || !bus.i_req || bus.i_ready) icnt <= 0;
    else icnt <= icnt + 1;
    if (rst || !bus.d_req || bus.d_ready) dcnt <= 0;
    else dcnt <= dcnt + 1;
    if (!rst && bus.d_req && bus.d_wen && bus.d_ready) dmem[bus.d_addr[7:2]] <= bus.d_wdata;
  end

  int ret_cnt = 0;
  int fetch_n = 0;
  logic [31:0] fetch_log [0:1023];
  always @(posedge clk) begin
    if (!rst && bus.retire) ret_cnt <= ret_cnt + 1;
    if (!rst && bus.i_req && bus.i_ready) begin
      fetch_log[fetch_n % 1024] <= bus.i_addr;
      fetch_n <= fetch_n + 1;
    end
  end

  // RV32E program: addi x1,x0,1 ; add x17,x1,x1 (illegal with 16 registers).
  logic [31:0] e_word;
  always_comb begin
    e_word = 32'h0000_0013;
    if (bus_e.i_addr == 32'd0) e_word = 32'h0010_0093;
    if (bus_e.i_addr == 32'd4) e_word = 32'h0010_88B3;
  end
  assign bus_e.i_rdata = bswap(e_word);
  assign bus_e.i_ready = bus_e.i_req;
  assign bus_e.d_rdata = 32'd0;
  assign bus_e.d_ready = 1'b0;

  int ret_snap = 0;
  int fetch_snap = 0;

  task automatic begin_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'd0;
      dmem[i] <= 32'd0;
    end
    i_lat = 0;
    st_lat = 0;
    ld_lat = 0;
    d_force = 1'b0;
  endtask

  task automatic end_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ret_snap = ret_cnt;
    fetch_snap = fetch_n;
  endtask

  task automatic run_to_pc(input string tag, input logic [31:0] pc);
    int n = 0;
    while (!(bus.i_req && bus.i_addr == pc) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, bus.i_addr, pc);
    check_eq({tag, "_req"}, 32'(bus.i_req), 32'd1);
  endtask

  // Follows one data access that completes on its 4th cycle (3 wait states).
  task automatic dphase(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n = 0;
    while (!bus.d_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, "_dreq"}, 32'(bus.d_req), 32'd1);
      check_eq({tag, "_daddr"}, bus.d_addr, addr);
      check_eq({tag, "_dwen"}, 32'(bus.d_wen), 32'(wen));
      if (wen) check_eq({tag, "_dwdata"}, bus.d_wdata, wdata);
      check_eq({tag, "_dready"}, 32'(bus.d_ready), (i == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check_eq({tag, "_retire"}, 32'(bus.retire), 32'd1);
    check_eq({tag, "_dreq_drop"}, 32'(bus.d_req), 32'd0);
  endtask

  initial begin
    // Reset state
    begin_reset();
    check_eq("rst_iaddr", bus.i_addr, 32'd0);
    check_eq("rst_ireq", 32'(bus.i_req), 32'd1);
    check_eq("rst_dreq", 32'(bus.d_req), 32'd0);
    check_eq("rst_dwen", 32'(bus.d_wen), 32'd0);
    check_eq("rst_daddr", bus.d_addr, 32'd0);
    check_eq("rst_dwdata", bus.d_wdata, 32'd0);
    check_eq("rst_retire", 32'(bus.retire), 32'd0);
    check_eq("rst_halted", 32'(bus.halted), 32'd0);

    // ALU path, zero-wait memories
    imem[0]  = 32'h0050_0093; // addi x1,x0,5
    imem[1]  = 32'hFFD0_0113; // addi x2,x0,-3
    imem[2]  = 32'h0020_81B3; // add  x3,x1,x2
    imem[3]  = 32'h4020_8233; // sub  x4,x1,x2
    imem[4]  = 32'h0011_22B3; // slt  x5,x2,x1
    imem[5]  = 32'h0020_F4B3; // and  x9,x1,x2
    imem[6]  = 32'h0020_E533; // or   x10,x1,x2
    imem[7]  = 32'h0030_2023; // sw x3,0(x0)
    imem[8]  = 32'h0040_2223; // sw x4,4(x0)
    imem[9]  = 32'h0050_2623; // sw x5,12(x0)
    imem[10] = 32'h0090_2823; // sw x9,16(x0)
    imem[11] = 32'h00A0_2A23; // sw x10,20(x0)
    end_reset();
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 0) check_eq($sformatf("alu_iaddr%0d", c), bus.i_addr, 32'(2 * c));
      check_eq($sformatf("alu_retire%0d", c), 32'(bus.retire),
               (c >= 2 && c % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    run_to_pc("alu_end", 32'd48);
    check_eq("alu_x3", dmem[0], bswap(32'd2));
    check_eq("alu_x4", dmem[1], bswap(32'd8));
    check_eq("alu_x5", dmem[3], bswap(32'd1));
    check_eq("alu_x9", dmem[4], bswap(32'd5));
    check_eq("alu_x10", dmem[5], bswap(32'hFFFF_FFFD));
    check_eq("e_halted", 32'(bus_e.halted), 32'd1);
    check_eq("e_ireq", 32'(bus_e.i_req), 32'd0);
    check_eq("e_pc", bus_e.i_addr, 32'd4);

    // Memory wait states
    begin_reset();
    imem[0] = 32'h0050_0093; // addi x1,x0,5
    imem[1] = 32'h0010_2423; // sw x1,8(x0)
    imem[2] = 32'h0080_2303; // lw x6,8(x0)
    imem[3] = 32'h0060_2C23; // sw x6,24(x0)
    i_lat = 2;
    st_lat = 3;
    ld_lat = 3;
    end_reset();
    dphase("sw", 1'b1, 32'd8, bswap(32'd5));
    dphase("lw", 1'b0, 32'd8, 32'd0);
    run_to_pc("mem_end", 32'd16);
    check_eq("mem_sw", dmem[2], bswap(32'd5));
    check_eq("mem_x6", dmem[6], bswap(32'd5));

    // Control flow
    begin_reset();
    imem[0] = 32'h0050_0093; // 0:  addi x1,x0,5
    imem[1] = 32'h0010_8463; // 4:  beq x1,x1,+8
    imem[2] = 32'h0010_0593; // 8:  addi x11,x0,1 (skipped)
    imem[3] = 32'h0010_9663; // 12: bne x1,x1,+12 (not taken)
    imem[4] = 32'h0080_006F; // 16: jal x0,+8
    imem[5] = 32'h0013_8467; // 20: jalr x8,x7,1
    imem[6] = 32'hFFDF_F3EF; // 24: jal x7,-4
    imem[7] = 32'h0070_2023; // 28: sw x7,0(x0)
    imem[8] = 32'h0080_2223; // 32: sw x8,4(x0)
    imem[9] = 32'h00B0_2423; // 36: sw x11,8(x0)
    dmem[2] <= 32'h0000_0099;
    end_reset();
    run_to_pc("cf_end", 32'd40);
    begin
      logic [31:0] exp_pc [0:8];
      exp_pc = '{32'd0, 32'd4, 32'd12, 32'd16, 32'd24, 32'd20, 32'd28, 32'd32, 32'd36};
      for (int k = 0; k < 9; k++)
        check_eq($sformatf("cf_fetch%0d", k), fetch_log[(fetch_snap + k) % 1024], exp_pc[k]);
    end
    check_eq("cf_x7", dmem[0], bswap(32'd28));
    check_eq("cf_x8", dmem[1], bswap(32'd24));
    check_eq("cf_x11", dmem[2], 32'd0);

    // x0 stays zero
    begin_reset();
    imem[0] = 32'h0090_0013; // addi x0,x0,9
    imem[1] = 32'h0000_2023; // sw x0,0(x0)
    dmem[0] <= 32'h1111_1111;
    end_reset();
    run_to_pc("x0_end", 32'd8);
    check_eq("x0_val", dmem[0], 32'd0);

    // Illegal instruction
    begin_reset();
    imem[0] = 32'h0050_0093; // addi x1,x0,5
    imem[1] = 32'hFFFF_FFFF;
    imem[2] = 32'h0010_2023; // sw x1,0(x0)
    dmem[0] <= 32'h0000_0077;
    end_reset();
    repeat (20) @(negedge clk);
    check_eq("ill_halted", 32'(bus.halted), 32'd1);
    check_eq("ill_ireq", 32'(bus.i_req), 32'd0);
    check_eq("ill_pc", bus.i_addr, 32'd4);
    check_eq("ill_retires", 32'(ret_cnt - ret_snap), 32'd1);
    check_eq("ill_nostore", dmem[0], 32'h0000_0077);

    // Misaligned jump target
    begin_reset();
    imem[0] = 32'h0050_0093; // addi x1,x0,5
    imem[1] = 32'h0020_076F; // jal x14,+2
    end_reset();
    repeat (20) @(negedge clk);
    check_eq("mis_halted", 32'(bus.halted), 32'd1);
    check_eq("mis_pc", bus.i_addr, 32'd4);
    check_eq("mis_retires", 32'(ret_cnt - ret_snap), 32'd1);

    // Reset while a load is outstanding
    begin_reset();
    imem[0] = 32'h00F0_2823; // sw x15,16(x0)
    imem[1] = 32'h0000_2783; // lw x15,0(x0)
    dmem[0] <= bswap(32'h0000_CAFE);
    dmem[4] <= 32'h0000_0055;
    ld_lat = 1000;
    end_reset();
    begin
      int n = 0;
      while (!(bus.d_req && !bus.d_wen) && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("rma_ld_pending", 32'(bus.d_req && !bus.d_wen), 32'd1);
    rst = 1'b1;
    i_lat = 1000;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rma_dreq", 32'(bus.d_req), 32'd0);
    check_eq("rma_pc", bus.i_addr, 32'd0);
    d_force = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rma_still_if", 32'(bus.d_req), 32'd0);
    d_force = 1'b0;
    i_lat = 0;
    ld_lat = 0;
    run_to_pc("rma_end", 32'd8);
    check_eq("rma_x15", dmem[4], 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
